// File: rtl/excpt_ctrl.sv
// Exception sequencer: sticky pending capture, priority take at
// instruction boundaries, vector lookup, redirect and eret return.
module excpt_ctrl #(
  parameter  int WIDTH     = 16,
  parameter  int NUM_EXC   = 16,
  localparam int ADDR_SIZE = $clog2(NUM_EXC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_EXC-1:0]   excpt_req,
  input  logic [NUM_EXC-1:0]   excpt_mask,
  input  logic [WIDTH-1:0]     pc,
  input  logic                 instr_done,
  input  logic                 eret,
  output logic [ADDR_SIZE-1:0] vec_addr,
  input  logic [WIDTH-1:0]     vec_data,
  output logic                 redirect,
  output logic [WIDTH-1:0]     pc_target,
  output logic                 stall,
  output logic [WIDTH-1:0]     epc,
  output logic [ADDR_SIZE-1:0] cause,
  output logic                 in_handler
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REDIRECT,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t               r_state;
  logic [NUM_EXC-1:0]   r_pend;
  logic [WIDTH-1:0]     r_epc;
  logic [ADDR_SIZE-1:0] r_cause;
  logic [ADDR_SIZE-1:0] r_vec_addr;
  logic                 r_redirect;
  logic                 r_stall;
  logic                 r_in_handler;

  logic [NUM_EXC-1:0]   w_eff;
  logic [ADDR_SIZE-1:0] w_sel;
  logic                 w_take;
  logic [NUM_EXC-1:0]   w_clr;

  assign w_eff  = (r_pend | excpt_req) & excpt_mask;
  assign w_take = (r_state == S_IDLE) && instr_done && (|w_eff);
  assign w_clr  = w_take ? (NUM_EXC'(1) << w_sel) : '0;

  // Downward scan so the lowest set index wins.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (w_eff[i]) w_sel = ADDR_SIZE'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= (r_pend | excpt_req) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_epc        <= '0;
      r_cause      <= '0;
      r_vec_addr   <= '0;
      r_redirect   <= 1'b0;
      r_stall      <= 1'b0;
      r_in_handler <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state    <= S_LOOKUP;
            r_cause    <= w_sel;
            r_vec_addr <= w_sel;
            r_epc      <= pc;
            r_stall    <= 1'b1;
          end
        end
        S_LOOKUP: begin
          r_state    <= S_REDIRECT;
          r_stall    <= 1'b1;
          r_redirect <= 1'b1;
        end
        S_REDIRECT: begin
          r_state      <= S_HANDLER;
          r_stall      <= 1'b0;
          r_redirect   <= 1'b0;
          r_in_handler <= 1'b1;
        end
        S_HANDLER: begin
          if (eret) begin
            r_state      <= S_RETURN;
            r_in_handler <= 1'b0;
            r_stall      <= 1'b1;
            r_redirect   <= 1'b1;
          end
        end
        S_RETURN: begin
          r_state    <= S_IDLE;
          r_stall    <= 1'b0;
          r_redirect <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_stall      <= 1'b0;
          r_redirect   <= 1'b0;
          r_in_handler <= 1'b0;
        end
      endcase
    end
  end

  // Vector data arrives during REDIRECT; RETURN goes back to epc.
  assign pc_target  = r_redirect
                    ? ((r_state == S_RETURN) ? r_epc : vec_data)
                    : '0;
  assign vec_addr   = r_vec_addr;
  assign redirect   = r_redirect;
  assign stall      = r_stall;
  assign epc        = r_epc;
  assign cause      = r_cause;
  assign in_handler = r_in_handler;

endmodule

// File: tb/tb_excpt_ctrl.sv
// Testbench for excpt_ctrl: directed scenarios plus a randomized run
// checked against a cycle-count based reference model.
module tb_excpt_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] excpt_req;
  logic [15:0] excpt_mask;
  logic [15:0] pc;
  logic        instr_done;
  logic        eret;
  logic [3:0]  vec_addr;
  logic [15:0] vec_data;
  logic        redirect;
  logic [15:0] pc_target;
  logic        stall;
  logic [15:0] epc;
  logic [3:0]  cause;
  logic        in_handler;

  logic [15:0] mem [16];
  int n_chk;
  int n_pass;

  excpt_ctrl #(.WIDTH(16), .NUM_EXC(16)) dut (
    .clk(clk), .rst(rst),
    .excpt_req(excpt_req), .excpt_mask(excpt_mask),
    .pc(pc), .instr_done(instr_done), .eret(eret),
    .vec_addr(vec_addr), .vec_data(vec_data),
    .redirect(redirect), .pc_target(pc_target),
    .stall(stall), .epc(epc), .cause(cause),
    .in_handler(in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) vec_data <= mem[vec_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    excpt_req  = '0;
    instr_done = 1'b0;
    eret       = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle_inputs();
    while (!in_handler && k < 20) begin
      tick();
      k++;
    end
    n_chk++;
    if (in_handler !== 1'b1)
      $display("FAIL drain_wait in_handler=%b required 1", in_handler);
    else n_pass++;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    excpt_req  = 16'hFFFF;
    excpt_mask = 16'h0000;
    tick();
    tick();
    n_chk++;
    if ({redirect, stall, in_handler, pc_target, epc, cause, vec_addr}
        !== 43'd0)
      $display("FAIL reset_outs got r%b s%b h%b t%h e%h c%0d v%0d req 0",
               redirect, stall, in_handler, pc_target, epc, cause,
               vec_addr);
    else n_pass++;
    excpt_req = '0;
    rst = 1'b1;
    tick();
    instr_done = 1'b1;
    tick();
    n_chk++;
    if (stall !== 1'b0)
      $display("FAIL reset_masked_take stall=%b required 0", stall);
    else n_pass++;
    excpt_mask = 16'hFFFF;
    tick();
    tick();
    n_chk++;
    if (stall !== 1'b0 || vec_addr !== 4'd0)
      $display("FAIL reset_pending_empty stall=%b vec=%0d required 0/0",
               stall, vec_addr);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_entry();
    excpt_mask = 16'hFFFF;
    excpt_req  = 16'h0020;
    instr_done = 1'b1;
    pc         = 16'h0104;
    tick();
    idle_inputs();
    n_chk++;
    if (vec_addr !== 4'd5 || stall !== 1'b1 || redirect !== 1'b0)
      $display("FAIL entry_lookup vec=%0d s=%b r=%b required 5/1/0",
               vec_addr, stall, redirect);
    else n_pass++;
    tick();
    n_chk++;
    if (redirect !== 1'b1 || pc_target !== 16'h8050 || stall !== 1'b1)
      $display("FAIL entry_redirect r=%b tgt=%h s=%b required 1/8050/1",
               redirect, pc_target, stall);
    else n_pass++;
    tick();
    n_chk++;
    if (cause !== 4'd5 || epc !== 16'h0104 || in_handler !== 1'b1 ||
        stall !== 1'b0 || redirect !== 1'b0)
      $display("FAIL entry_handler c=%0d epc=%h h=%b s=%b r=%b req 5/0104/1/0/0",
               cause, epc, in_handler, stall, redirect);
    else n_pass++;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    n_chk++;
    if (redirect !== 1'b1 || pc_target !== 16'h0104 || in_handler !== 1'b0)
      $display("FAIL entry_return r=%b tgt=%h h=%b required 1/0104/0",
               redirect, pc_target, in_handler);
    else n_pass++;
    tick();
    n_chk++;
    if (redirect !== 1'b0 || stall !== 1'b0 || pc_target !== 16'h0)
      $display("FAIL entry_idle r=%b s=%b tgt=%h required 0/0/0000",
               redirect, stall, pc_target);
    else n_pass++;
  endtask

  task automatic test_priority_nesting();
    excpt_mask = 16'hFFFF;
    excpt_req  = 16'h0A00;
    instr_done = 1'b1;
    pc         = 16'h0200;
    tick();
    idle_inputs();
    n_chk++;
    if (vec_addr !== 4'd9)
      $display("FAIL prio_first vec=%0d required 9", vec_addr);
    else n_pass++;
    tick();
    tick();
    excpt_req  = 16'h0004;
    instr_done = 1'b1;
    tick();
    excpt_req = '0;
    tick();
    tick();
    n_chk++;
    if (in_handler !== 1'b1 || stall !== 1'b0 || cause !== 4'd9)
      $display("FAIL prio_no_nest h=%b s=%b c=%0d required 1/0/9",
               in_handler, stall, cause);
    else n_pass++;
    instr_done = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    n_chk++;
    if (redirect !== 1'b1 || pc_target !== 16'h0200)
      $display("FAIL prio_return r=%b tgt=%h required 1/0200",
               redirect, pc_target);
    else n_pass++;
    tick();
    instr_done = 1'b1;
    pc = 16'h0300;
    tick();
    instr_done = 1'b0;
    n_chk++;
    if (vec_addr !== 4'd2 || stall !== 1'b1)
      $display("FAIL prio_second vec=%0d s=%b required 2/1", vec_addr, stall);
    else n_pass++;
    drain();
    instr_done = 1'b1;
    pc = 16'h0400;
    tick();
    instr_done = 1'b0;
    n_chk++;
    if (vec_addr !== 4'd11 || stall !== 1'b1)
      $display("FAIL prio_third vec=%0d s=%b required 11/1", vec_addr, stall);
    else n_pass++;
    drain();
  endtask

  task automatic test_masking();
    int bad;
    excpt_mask = 16'hFFF7;
    excpt_req  = 16'h0008;
    tick();
    excpt_req  = '0;
    instr_done = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stall !== 1'b0 || in_handler !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0)
      $display("FAIL mask_hold busy_cycles=%0d required 0", bad);
    else n_pass++;
    excpt_mask = 16'hFFFF;
    pc = 16'h0500;
    tick();
    instr_done = 1'b0;
    n_chk++;
    if (vec_addr !== 4'd3 || stall !== 1'b1)
      $display("FAIL mask_unmask vec=%0d s=%b required 3/1", vec_addr, stall);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    excpt_mask = 16'hFFFF;
    excpt_req  = 16'h0050;
    instr_done = 1'b1;
    pc         = 16'h0444;
    tick();
    idle_inputs();
    tick();
    n_chk++;
    if (redirect !== 1'b1)
      $display("FAIL rmid_in_redirect r=%b required 1", redirect);
    else n_pass++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_chk++;
    if ({redirect, stall, in_handler, pc_target, epc, cause, vec_addr}
        !== 43'd0)
      $display("FAIL rmid_abort r%b s%b h%b t%h e%h c%0d v%0d required 0",
               redirect, stall, in_handler, pc_target, epc, cause,
               vec_addr);
    else n_pass++;
    tick();
    instr_done = 1'b1;
    tick();
    tick();
    instr_done = 1'b0;
    n_chk++;
    if (stall !== 1'b0 || in_handler !== 1'b0)
      $display("FAIL rmid_pend_lost s=%b h=%b required 0/0", stall, in_handler);
    else n_pass++;
  endtask

  task automatic test_eret_idle();
    excpt_mask = 16'hFFFF;
    eret       = 1'b1;
    excpt_req  = 16'h1000;
    tick();
    idle_inputs();
    n_chk++;
    if (redirect !== 1'b0 || stall !== 1'b0)
      $display("FAIL eret_idle r=%b s=%b required 0/0", redirect, stall);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (stall !== 1'b0 || in_handler !== 1'b0)
      $display("FAIL req_no_done s=%b h=%b required 0/0", stall, in_handler);
    else n_pass++;
    instr_done = 1'b1;
    pc = 16'h0555;
    tick();
    instr_done = 1'b0;
    n_chk++;
    if (vec_addr !== 4'd12 || stall !== 1'b1)
      $display("FAIL req_later_take vec=%0d s=%b required 12/1",
               vec_addr, stall);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic [15:0] m_pend, m_epc, eff, low;
    logic [3:0]  m_cause;
    logic [42:0] exp_v, got_v;
    logic        e_stall, e_red, e_inh, busy;
    logic [15:0] e_tgt;
    int c, t_take, t_eret;
    bit sess, edone;
    rst = 1'b0;
    idle_inputs();
    excpt_mask = 16'hFFFF;
    tick();
    rst = 1'b1;
    m_pend = '0; m_epc = '0; m_cause = '0;
    sess = 0; edone = 0; c = 0; t_take = -10; t_eret = -10;
    for (int i = 0; i < 600; i++) begin
      tick();
      c++;
      e_stall = 0; e_red = 0; e_inh = 0; e_tgt = '0;
      if (sess && c == t_take + 1) e_stall = 1;
      else if (sess && c == t_take + 2) begin
        e_stall = 1; e_red = 1; e_tgt = mem[m_cause];
      end else if (sess && c >= t_take + 3 && (!edone || c <= t_eret))
        e_inh = 1;
      else if (sess && edone && c == t_eret + 1) begin
        e_stall = 1; e_red = 1; e_tgt = m_epc;
      end
      exp_v = {e_stall, e_red, e_inh, e_tgt, m_cause, m_epc, m_cause};
      got_v = {stall, redirect, in_handler, pc_target, cause, epc, vec_addr};
      n_chk++;
      if (got_v !== exp_v)
        $display("FAIL rand_cycle%0d got %h required %h", c, got_v, exp_v);
      else n_pass++;
      if (i % 64 == 0)
        excpt_mask = $urandom_range(0, 1) ? 16'hFFFF : 16'($urandom);
      excpt_req  = ($urandom_range(0, 5) == 0)
                 ? (16'h1 << $urandom_range(0, 15)) | 16'($urandom & 32'h0101)
                 : 16'h0;
      instr_done = ($urandom_range(0, 1) == 1);
      eret       = ($urandom_range(0, 3) == 0);
      pc         = 16'($urandom);
      busy = sess && !(edone && c >= t_eret + 2);
      eff  = (m_pend | excpt_req) & excpt_mask;
      if (!busy && instr_done && eff != 0) begin
        low     = eff & (~eff + 16'd1);
        m_cause = 4'($clog2(low));
        m_epc   = pc;
        m_pend  = (m_pend | excpt_req) & ~low;
        sess = 1; edone = 0; t_take = c;
      end else begin
        m_pend = m_pend | excpt_req;
      end
      if (sess && !edone && c >= t_take + 3 && eret) begin
        edone = 1; t_eret = c;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    excpt_req = '0;
    excpt_mask = '0;
    pc = '0;
    instr_done = 1'b0;
    eret = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h8000 + 16'(i * 16);
    test_reset();
    test_single_entry();
    test_priority_nesting();
    test_masking();
    test_reset_mid();
    test_eret_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/excpt_ctrl.md
# excpt_ctrl

Exception sequencer for the 16-bit single-cycle CPU. Captures raised exceptions into a sticky pending register and selects the highest-priority enabled one at an instruction boundary. It reads the handler address from the synchronous handler-vector memory, saves the return PC, and redirects fetch. It then blocks further entries until return-from-exception. The block sits between the exception sources, the vector memory and the PC/fetch logic.

## Interface
- WIDTH, 16, data/PC width and vector memory word width
- NUM_EXC, 16, number of exception sources; index 0 is highest priority
- ADDR_SIZE, $clog2(NUM_EXC), derived localparam: cause/vector index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- excpt_req  in  NUM_EXC  exception raise strobes, any bit pattern, any cycle
- excpt_mask  in  NUM_EXC  per-source enable, 1 = may be taken
- pc  in  WIDTH  PC of instruction retiring this cycle
- instr_done  in  1  instruction boundary; exceptions are only taken here
- eret  in  1  return-from-exception executed this cycle
- vec_addr  out  ADDR_SIZE  registered index into handler-vector memory
- vec_data  in  WIDTH  vector memory read data, valid one cycle after vec_addr is sampled
- redirect  out  1  one-cycle pulse: fetch must load pc_target
- pc_target  out  WIDTH  redirect target, meaningful only while redirect=1
- stall  out  1  hold fetch/retire
- epc  out  WIDTH  saved return PC
- cause  out  ADDR_SIZE  index of the exception being serviced
- in_handler  out  1  1 while a handler is running

## Operation
- pending register: pending <= (pending | excpt_req) & ~take_clr each cycle, in every state. Requests are never dropped. Masked bits stay pending until unmasked.
- eff = (pending | excpt_req) & excpt_mask. Selected index sel = lowest set bit of eff.
- FSM states: IDLE, LOOKUP, REDIRECT, HANDLER, RETURN.
- IDLE: if instr_done and |eff, do all of the following, then go to LOOKUP:
  - cause <= sel, vec_addr <= sel, epc <= pc
  - clear pending[sel], including a same-cycle excpt_req[sel] (consumed as one event)
- IDLE: otherwise stay.
- LOOKUP: stall=1. vec_addr is stable and sampled by the memory at the end of the cycle. Always go to REDIRECT.
- REDIRECT: stall=1, redirect=1, pc_target=vec_data. Go to HANDLER.
- HANDLER: in_handler=1, no stall. instr_done does not cause a take (no nesting); requests accumulate. On eret go to RETURN.
- RETURN: stall=1, redirect=1, pc_target=epc, in_handler=0. Go to IDLE. instr_done is ignored here.
- eret outside HANDLER is ignored.
- Outputs not listed for a state are 0. pc_target is 0 when redirect=0.
- epc, cause and vec_addr hold their values until the next take.
- No arithmetic on PC: epc is the PC of the boundary instruction. Skipping the faulting instruction is the handler's job.

## Timing
- Reset (rst=0 at an edge): state=IDLE, pending=0, epc=0, cause=0, vec_addr=0. redirect, stall, in_handler and pc_target are all 0 from the next cycle.
- Reset mid-operation (any state): abort to IDLE with no redirect. Pending requests are lost.
- Entry latency: take at cycle N (IDLE, instr_done). LOOKUP at N+1, REDIRECT (redirect pulse) at N+2, HANDLER at N+3.
- Exit latency: eret at cycle M (HANDLER). RETURN (redirect to epc) at M+1, IDLE at M+2.
- Earliest re-entry: a take is possible at M+2 if instr_done=1 and eff≠0.
- redirect is exactly one cycle wide. stall=1 in LOOKUP, REDIRECT and RETURN only.
- All masked, or eff=0: no state change, outputs stay 0.

## Test plan
- Reset: hold rst=0 for 2 cycles with excpt_req=16'hFFFF -> all outputs 0, pending empty; after release with mask=0 there is no take.
- Single entry: mask=16'hFFFF, excpt_req=16'h0020 at N with instr_done=1, pc=16'h0104, memory[5]=16'h8050.
  - vec_addr=5 at N+1.
  - redirect=1 with pc_target=16'h8050 at N+2.
  - cause=5, epc=16'h0104, in_handler=1 at N+3.
- Priority and no-nesting: excpt_req=16'h0A00 (bits 9 and 11) -> bit 9 taken first.
  - Raising bit 2 in HANDLER causes no take.
  - After eret: RETURN redirect to epc.
  - Next take (bit 2) at the first instr_done in IDLE; bit 11 follows after the second eret.
- Masking: excpt_req bit 3 with mask bit 3=0 -> no take over 10 instr_done cycles. Unmask -> bit 3 taken at the next instr_done.
- Reset mid-operation: rst=0 during REDIRECT -> state IDLE, redirect=0 next cycle, pending=0, epc=0.
- eret in IDLE and a request without instr_done -> no redirect, no state change. Request stays pending and is taken at a later instr_done.
